// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Holds the state enum, opcode constants, datapath select encodings and the control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       memwrite;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: opcode/memory status in, every select and enable out.
interface multicycle_controller_if;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        mem_req;
    logic        iord;
    logic        irwrite;
    logic        pcwrite;
    logic        branch;
    logic [1:0]  pcsrc;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic [1:0]  aluop;
    logic        regwrite;
    logic        regdst;
    logic        memtoreg;
    logic        memwrite;
    logic        illegal;
    logic [31:0] retired;

    modport master (
        input  opcode, mem_ready,
        output mem_req, iord, irwrite, pcwrite, branch, pcsrc, alusrca, alusrcb,
               aluop, regwrite, regdst, memtoreg, memwrite, illegal, retired
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, iord, irwrite, pcwrite, branch, pcsrc, alusrca, alusrcb,
               aluop, regwrite, regdst, memtoreg, memwrite, illegal, retired
    );
endinterface

// File: rtl/multicycle_output_decoder.sv
// Moore output decode: state (plus mem_ready in FETCH) to the datapath control word.
module multicycle_output_decoder
    import mips_ctrl_pkg::*;
(
    input  state_t state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.alusrcb = SRCB_FOUR;
                ctrl_o.aluop   = ALUOP_ADD;
                ctrl_o.pcsrc   = PCSRC_ALU;
                // IR and PC only commit on the cycle the fetch actually completes
                ctrl_o.irwrite = mem_ready_i;
                ctrl_o.pcwrite = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alusrcb = SRCB_IMMSH;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_req  = 1'b1;
                ctrl_o.iord     = 1'b1;
                ctrl_o.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_REGB;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.regdst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_REGB;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.pcsrc   = PCSRC_ALUOUT;
                ctrl_o.branch  = 1'b1;
            end
            S_ADDIWB: begin
                ctrl_o.regwrite = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pcsrc   = PCSRC_JUMP;
                ctrl_o.pcwrite = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: state register, next-state logic and retired-instruction counter.
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    multicycle_controller_if.master bus
);

    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        retire;
    ctrl_t       ctrl_raw, ctrl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Only real completions count; DECODE -> FETCH on an illegal opcode does not.
    always_comb begin
        retire    = (state_d == S_FETCH) &&
                    (state_q inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP});
        retired_d = retire ? retired_q + 32'd1 : retired_q;
    end

    multicycle_output_decoder u_dec (
        .state_i     (state_q),
        .mem_ready_i (bus.mem_ready),
        .ctrl_o      (ctrl_raw)
    );

    // State sits in FETCH during reset, so the control word is masked explicitly.
    assign ctrl = reset_n ? ctrl_raw : '0;

    assign bus.mem_req  = ctrl.mem_req;
    assign bus.iord     = ctrl.iord;
    assign bus.irwrite  = ctrl.irwrite;
    assign bus.pcwrite  = ctrl.pcwrite;
    assign bus.branch   = ctrl.branch;
    assign bus.pcsrc    = ctrl.pcsrc;
    assign bus.alusrca  = ctrl.alusrca;
    assign bus.alusrcb  = ctrl.alusrcb;
    assign bus.aluop    = ctrl.aluop;
    assign bus.regwrite = ctrl.regwrite;
    assign bus.regdst   = ctrl.regdst;
    assign bus.memtoreg = ctrl.memtoreg;
    assign bus.memwrite = ctrl.memwrite;
    assign bus.illegal  = reset_n && (state_q == S_DECODE) && !op_supported(bus.opcode);
    assign bus.retired  = retired_q;

endmodule
